// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch FSM encoding, reset PC and base opcodes
// used by both the fetch stage and the main decoder.
package riscv_pkg;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t ST_IDLE = 2'd0;
   localparam fetch_state_t ST_REQ  = 2'd1;
   localparam fetch_state_t ST_WAIT = 2'd2;
   localparam fetch_state_t ST_DROP = 2'd3;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between fetch and decode.
// Flush wins over push/pop in the same cycle.
module fetch_buffer #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   input  logic         flush,
   output logic [1:0]   occ,
   output logic [W-1:0] head
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: ;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one word request at a time and
// buffers returned instructions for decode; redirects flush and drop stale data.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic [6:0]      inst_op
);

   fetch_state_t      state, state_nxt;
   logic [XLEN-1:0]   pc, pc_nxt;
   logic [XLEN-1:0]   target;
   logic              req_hs;
   logic              push;
   logic              pop;
   logic [1:0]        occ;
   logic [2*XLEN-1:0] head;

   // Targets are word aligned; low bits of the branch address are dropped.
   assign target         = redirect_pc & ~XLEN'(3);
   assign imem_req_valid = (state == ST_REQ) && (occ < 2'd2);
   assign imem_req_addr  = pc;
   assign req_hs         = imem_req_valid && imem_req_ready;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      push      = 1'b0;
      case (state)
         ST_IDLE: state_nxt = ST_REQ;
         ST_REQ: begin
            // A request accepted alongside a redirect is already stale.
            if (req_hs)
               state_nxt = redirect_valid ? ST_DROP : ST_WAIT;
         end
         ST_WAIT: begin
            if (redirect_valid)
               state_nxt = imem_rsp_valid ? ST_REQ : ST_DROP;
            else if (imem_rsp_valid) begin
               push      = 1'b1;
               pc_nxt    = pc + XLEN'(4);
               state_nxt = ST_REQ;
            end
         end
         ST_DROP: begin
            if (imem_rsp_valid)
               state_nxt = ST_REQ;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (redirect_valid)
         pc_nxt = target;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   assign pop = inst_valid && inst_ready;

   fetch_buffer #(.W(2*XLEN)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({pc, imem_rsp_data}),
      .pop       (pop),
      .flush     (redirect_valid),
      .occ       (occ),
      .head      (head)
   );

   assign inst_valid = (occ != 2'd0);
   assign inst_pc    = head[2*XLEN-1:XLEN];
   assign inst_data  = head[XLEN-1:0];
   assign inst_op    = inst_data[6:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming with stall, redirects,
// PC wrap and mid-transaction reset.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [6:0]  inst_op;

   int n_run  = 0;
   int n_fail = 0;
   bit auto_mem;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_op        (inst_op)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0050_0093 ^ {a[15:0], 16'h0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One cycle; optional 1-cycle-latency memory answers the handshake just taken.
   task automatic tick();
      logic        hs;
      logic [31:0] a;
      hs = imem_req_valid && imem_req_ready;
      a  = imem_req_addr;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      if (auto_mem) begin
         imem_rsp_valid = hs;
         imem_rsp_data  = mem_word(a);
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      #1;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   logic [31:0] got_pc [3];
   logic [31:0] got_d  [3];
   int          n;

   initial begin
      rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0; auto_mem = 1'b1;

      // reset and first fetch
      #2;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_inst_data", inst_data, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      @(posedge clk); #1; rst_n = 1'b1;
      tick();
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", imem_req_addr, 32'h0);
      tick();
      chk("wait_no_req", 32'(imem_req_valid), 32'd0);
      tick();
      chk("first_inst_valid", 32'(inst_valid), 32'd1);
      chk("first_inst_pc", inst_pc, 32'h0);
      chk("first_inst_op", 32'(inst_op), 32'h13);
      chk("first_inst_data", inst_data, 32'h0050_0093);
      chk("next_req_addr", imem_req_addr, 32'h4);

      // decode stall fills the buffer
      tick();
      tick();
      chk("full_req_valid", 32'(imem_req_valid), 32'd0);
      chk("full_inst_valid", 32'(inst_valid), 32'd1);
      for (int i = 0; i < 3; i++) tick();
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_head_pc", inst_pc, 32'h0);
      inst_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 20 && n < 3; i++) begin
         if (inst_valid) begin
            got_pc[n] = inst_pc;
            got_d[n]  = inst_data;
            n++;
         end
         tick();
      end
      chk("drain_count", 32'(n), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk("drain_pc", got_pc[i], 32'(4 * i));
         chk("drain_data", got_d[i], mem_word(32'(4 * i)));
      end
      inst_ready = 1'b0;

      // redirect while waiting: late response discarded
      auto_mem = 1'b0;
      inst_ready = 1'b1;
      do_reset();
      tick();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick();
      chk("wredir_inst_valid", 32'(inst_valid), 32'd0);
      chk("wredir_drop_noreq", 32'(imem_req_valid), 32'd0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      tick();
      imem_rsp_valid = 1'b0;
      chk("wredir_discard", 32'(inst_valid), 32'd0);
      chk("wredir_req_valid", 32'(imem_req_valid), 32'd1);
      chk("wredir_req_addr", imem_req_addr, 32'h100);
      tick();
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0113;
      tick();
      imem_rsp_valid = 1'b0;
      chk("wredir_inst_pc", inst_pc, 32'h100);
      chk("wredir_inst_data", inst_data, 32'h0000_0113);

      // redirect with handshake -> drop; redirect with response -> no push
      do_reset();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      tick();
      chk("hsredir_drop_noreq", 32'(imem_req_valid), 32'd0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0013;
      tick();
      imem_rsp_valid = 1'b0;
      chk("hsredir_discard", 32'(inst_valid), 32'd0);
      chk("hsredir_req_addr", imem_req_addr, 32'h200);
      tick();
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD1_0013;
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      tick();
      imem_rsp_valid = 1'b0;
      chk("rspredir_no_push", 32'(inst_valid), 32'd0);
      chk("rspredir_req_valid", 32'(imem_req_valid), 32'd1);
      chk("rspredir_align", imem_req_addr, 32'h200);
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h300;
      tick();
      chk("reqredir_stay", 32'(imem_req_valid), 32'd1);
      chk("reqredir_addr", imem_req_addr, 32'h300);

      // PC wrap-around
      auto_mem = 1'b1;
      do_reset();
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      imem_req_ready = 1'b1;
      chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      tick();
      tick();
      chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
      chk("wrap_next_addr", imem_req_addr, 32'h0);
      chk("wrap_next_valid", 32'(imem_req_valid), 32'd1);

      // reset in WAIT with one buffered entry
      inst_ready = 1'b0;
      do_reset();
      tick();
      tick();
      tick();
      tick();
      chk("pre_rst_inst_valid", 32'(inst_valid), 32'd1);
      rst_n = 1'b0;
      imem_rsp_valid = 1'b0;
      #1;
      chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("mid_rst_req_addr", imem_req_addr, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
      chk("restart_req_addr", imem_req_addr, 32'h0);
      chk("restart_inst_valid", 32'(inst_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
